// File: rtl/gol_pkg.sv
// Shared types and constants for the Game-of-Life grid engine.
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [8:0] RULE_B3S23_BIRTH = 9'h008;
  localparam logic [8:0] RULE_B3S23_SURV  = 9'h00C;
  localparam int         NBR_W            = 4;

endpackage

// File: rtl/gol_cell_rule.sv
// One cell's next state from its eight neighbours and the birth/survive masks.
module gol_cell_rule
  import gol_pkg::*;
(
  input  logic [7:0] nbrs,
  input  logic       self_alive,
  input  logic [8:0] birth_mask,
  input  logic [8:0] surv_mask,
  output logic       next_alive
);

  logic [NBR_W-1:0] live_cnt;

  always_comb begin
    live_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      live_cnt = live_cnt + {{(NBR_W-1){1'b0}}, nbrs[i]};
    end
  end

  assign next_alive = self_alive ? surv_mask[live_cnt] : birth_mask[live_cnt];

endmodule

// File: rtl/gol_grid_engine.sv
// Game-of-Life grid engine: row-wise load, single-step and free-run generation updates.
//  state | meaning
//  IDLE  | waiting; accepts first load beat, step or run
//  LOAD  | accepting rows 1..ROWS-1 into the grid
//  RUN   | one generation per cycle while run is high
module gol_grid_engine
  import gol_pkg::*;
#(
  parameter int         COLS       = 32,
  parameter int         ROWS       = 18,
  parameter int         WRAP       = 0,
  parameter logic [8:0] BIRTH_MASK = RULE_B3S23_BIRTH,
  parameter logic [8:0] SURV_MASK  = RULE_B3S23_SURV,
  parameter int         GEN_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [COLS-1:0]      load_row,
  input  logic                 step,
  input  logic                 run,
  input  logic                 halt_stable,
  output logic [ROWS*COLS-1:0] cells,
  output logic [GEN_W-1:0]     generation,
  output logic                 stable,
  output logic                 busy
);

  localparam int ROW_W = $clog2(ROWS);

  state_t                 state, state_nxt;
  logic [ROW_W-1:0]       row_ptr;
  logic [ROWS*COLS-1:0]   grid, grid_nxt;
  logic                   do_write, do_update, last_row;

  assign cells    = grid;
  assign last_row = (row_ptr == ROW_W'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_valid) state_nxt = LOAD;
               else if (run)   state_nxt = RUN;
      LOAD:    if (load_valid && last_row) state_nxt = IDLE;
      RUN:     if (!run || (halt_stable && stable)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b1;
    do_write   = 1'b0;
    do_update  = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        busy       = 1'b0;
        do_write   = load_valid;
        do_update  = !load_valid && (step || run);
      end
      LOAD: begin
        load_ready = 1'b1;
        do_write   = load_valid;
      end
      // a stable generation already on the grid halts without another update
      RUN:     do_update = run && !(halt_stable && stable);
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grid       <= '0;
      row_ptr    <= '0;
      generation <= '0;
      stable     <= 1'b0;
    end else if (do_write) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row_ptr == ROW_W'(r)) grid[r*COLS +: COLS] <= load_row;
      end
      if (state == LOAD && last_row) begin
        row_ptr    <= '0;
        generation <= '0;
        stable     <= 1'b0;
      end else begin
        row_ptr <= row_ptr + ROW_W'(1);
      end
    end else if (do_update) begin
      grid       <= grid_nxt;
      generation <= generation + GEN_W'(1);
      stable     <= (grid_nxt == grid);
    end
  end

  // neighbour k (0..8, skipping centre 4) sits at row offset k/3-1, column offset k%3-1
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nbrs;
      for (genvar k = 0; k < 9; k++) begin : g_nbr
        if (k != 4) begin : g_use
          localparam int  RR_RAW = r + k / 3 - 1;
          localparam int  CC_RAW = c + k % 3 - 1;
          localparam int  RR     = (WRAP != 0) ? (RR_RAW + ROWS) % ROWS : RR_RAW;
          localparam int  CC     = (WRAP != 0) ? (CC_RAW + COLS) % COLS : CC_RAW;
          localparam bit  INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
          localparam int  IDX    = INSIDE ? RR * COLS + CC : 0;
          localparam int  NB     = (k < 4) ? k : k - 1;
          if (INSIDE) begin : g_in
            assign nbrs[NB] = grid[IDX];
          end else begin : g_out
            assign nbrs[NB] = 1'b0;
          end
        end
      end

      gol_cell_rule u_rule (
        .nbrs       (nbrs),
        .self_alive (grid[r*COLS+c]),
        .birth_mask (BIRTH_MASK),
        .surv_mask  (SURV_MASK),
        .next_alive (grid_nxt[r*COLS+c])
      );
    end
  end

endmodule

// File: tb/tb_gol_grid_engine.sv
// Directed bench for gol_grid_engine: dead-border 32x18 and toroidal 32x16 instances.
module tb_gol_grid_engine;

  localparam int COLS   = 32;
  localparam int ROWS_D = 18;
  localparam int ROWS_W = 16;
  localparam int N      = ROWS_D * COLS;
  localparam int NW     = ROWS_W * COLS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, step, run, halt_stable, lv_d, lv_w;
  logic [COLS-1:0] load_row;
  logic            lr_d, lr_w, st_d, st_w, busy_d, busy_w;
  logic [N-1:0]    cells_d;
  logic [NW-1:0]   cells_w;
  logic [15:0]     gen_d, gen_w;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string        tag;
    bit           w;
    logic [N-1:0] cells;
    logic [15:0]  gen;
    logic         stable;
    logic         busy;
  } exp_t;
  exp_t sb[$];

  gol_grid_engine #(.COLS(COLS), .ROWS(ROWS_D), .WRAP(0)) dut_d (
    .clk(clk), .rst(rst), .load_valid(lv_d), .load_ready(lr_d), .load_row(load_row),
    .step(step), .run(run), .halt_stable(halt_stable), .cells(cells_d),
    .generation(gen_d), .stable(st_d), .busy(busy_d)
  );

  gol_grid_engine #(.COLS(COLS), .ROWS(ROWS_W), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .load_valid(lv_w), .load_ready(lr_w), .load_row(load_row),
    .step(step), .run(run), .halt_stable(halt_stable), .cells(cells_w),
    .generation(gen_w), .stable(st_w), .busy(busy_w)
  );

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input bit w, input logic [N-1:0] c,
                      input logic [15:0] g, input logic s, input logic b);
    exp_t e;
    e.tag = tag; e.w = w; e.cells = c; e.gen = g; e.stable = s; e.busy = b;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, "_cells"},  e.w ? {{(N-NW){1'b0}}, cells_w} : cells_d, e.cells);
    check({e.tag, "_gen"},    N'(e.w ? gen_w : gen_d), N'(e.gen));
    check({e.tag, "_stable"}, N'(e.w ? st_w : st_d), N'(e.stable));
    check({e.tag, "_busy"},   N'(e.w ? busy_w : busy_d), N'(e.busy));
  endtask

  function automatic logic [N-1:0] put(input logic [N-1:0] g, input int r, input int c);
    logic [N-1:0] t;
    t = g;
    t[r*COLS+c] = 1'b1;
    return t;
  endfunction

  // reference Life step, B3/S23 written as explicit counts
  function automatic logic [N-1:0] life_next(input logic [N-1:0] g, input int rows, input bit wrap);
    logic [N-1:0] nx;
    int n, rr, cc;
    nx = '0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
              if (wrap) begin
                rr = (rr + rows) % rows;
                cc = (cc + COLS) % COLS;
              end
              if (rr >= 0 && rr < rows && cc >= 0 && cc < COLS && g[rr*COLS+cc]) n++;
            end
          end
        end
        if (g[r*COLS+c]) nx[r*COLS+c] = (n == 2 || n == 3);
        else             nx[r*COLS+c] = (n == 3);
      end
    end
    return nx;
  endfunction

  task automatic load_grid(input bit w, input logic [N-1:0] g, input bit gaps, input bit poke,
                           input logic [15:0] gen_hold);
    int rows;
    rows = w ? ROWS_W : ROWS_D;
    for (int r = 0; r < rows; r++) begin
      if (gaps && (r % 3 == 2)) begin
        lv_d = 1'b0; lv_w = 1'b0; step = poke; run = poke;
        @(negedge clk);
        check("load_gap_gen",  N'(w ? gen_w : gen_d), N'(gen_hold));
        check("load_gap_busy", N'(w ? busy_w : busy_d), N'(1'b1));
      end
      load_row = g[r*COLS +: COLS];
      if (w) lv_w = 1'b1; else lv_d = 1'b1;
      step = poke; run = poke;
      check("load_ready", N'(w ? lr_w : lr_d), N'(1'b1));
      @(negedge clk);
    end
    lv_d = 1'b0; lv_w = 1'b0; step = 1'b0; run = 1'b0;
  endtask

  task automatic step_pulse();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    pop_check();
  endtask

  initial begin
    logic [N-1:0] g, m, nx, vert, blk, pat;
    logic [15:0]  gen;
    logic         st_m, busy_m, prev_st;

    rst = 1'b1; step = 1'b0; run = 1'b0; halt_stable = 1'b0;
    lv_d = 1'b0; lv_w = 1'b0; load_row = '0;
    repeat (2) @(negedge clk);
    push("reset", 0, '0, 16'd0, 1'b0, 1'b0);
    pop_check();
    check("reset_ready", N'(lr_d), N'(1'b1));
    rst = 1'b0;

    // blinker oscillates with period 2
    g = '0; g = put(g, 9, 15); g = put(g, 9, 16); g = put(g, 9, 17);
    load_grid(0, g, 0, 0, 16'd0);
    push("t1_load", 0, g, 16'd0, 1'b0, 1'b0); pop_check();
    vert = '0; vert = put(vert, 8, 16); vert = put(vert, 9, 16); vert = put(vert, 10, 16);
    push("t1_step1", 0, vert, 16'd1, 1'b0, 1'b0); step_pulse();
    push("t1_step2", 0, g, 16'd2, 1'b0, 1'b0);    step_pulse();

    // still life halts free-run after one update
    blk = '0; blk = put(blk, 4, 4); blk = put(blk, 4, 5); blk = put(blk, 5, 4); blk = put(blk, 5, 5);
    load_grid(0, blk, 0, 0, 16'd0);
    push("t2_load", 0, blk, 16'd0, 1'b0, 1'b0); pop_check();
    run = 1'b1; halt_stable = 1'b1;
    push("t2_run", 0, blk, 16'd1, 1'b1, 1'b1);
    @(negedge clk); pop_check();
    check("t2_ready_in_run", N'(lr_d), N'(1'b0));
    push("t2_halt", 0, blk, 16'd1, 1'b1, 1'b0);
    @(negedge clk); run = 1'b0; pop_check();

    // glider into the dead bottom-right corner collapses to a block
    g = '0; g = put(g, 15, 30); g = put(g, 16, 31); g = put(g, 17, 29); g = put(g, 17, 30); g = put(g, 17, 31);
    load_grid(0, g, 0, 0, 16'd0);
    push("t4_load", 0, g, 16'd0, 1'b0, 1'b0); pop_check();
    m = g; gen = 16'd0; st_m = 1'b0; busy_m = 1'b0;
    run = 1'b1; halt_stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (busy_m && st_m) begin
        push("t4_halt", 0, m, gen, st_m, 1'b0);
        @(negedge clk); run = 1'b0; pop_check();
        break;
      end
      nx = life_next(m, ROWS_D, 1'b0);
      st_m = (nx == m); m = nx; gen++; busy_m = 1'b1;
      push("t4_gen", 0, m, gen, st_m, 1'b1);
      @(negedge clk); pop_check();
      check("t4_row0", N'(cells_d[COLS-1:0]), '0);
    end
    run = 1'b0; halt_stable = 1'b0;
    blk = '0; blk = put(blk, 16, 30); blk = put(blk, 16, 31); blk = put(blk, 17, 30); blk = put(blk, 17, 31);
    push("t4_final", 0, blk, 16'd4, 1'b1, 1'b0);
    @(negedge clk); pop_check();

    // toroidal glider returns home after 4*COLS generations on a 32x16 torus
    g = '0; g = put(g, 0, 1); g = put(g, 1, 2); g = put(g, 2, 0); g = put(g, 2, 1); g = put(g, 2, 2);
    load_grid(1, g, 0, 0, 16'd0);
    push("t3_load", 1, g, 16'd0, 1'b0, 1'b0); pop_check();
    m = g; gen = 16'd0; prev_st = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 4 * COLS; i++) begin
      nx = life_next(m, ROWS_W, 1'b1);
      prev_st = (nx == m); m = nx; gen++;
      push("t3_gen", 1, m, gen, prev_st, 1'b1);
      @(negedge clk); pop_check();
    end
    run = 1'b0;
    push("t3_stop", 1, g, 16'd128, prev_st, 1'b0);
    @(negedge clk); pop_check();

    // random pattern on the torus exercises wrap on every edge
    for (int r = 0; r < ROWS_W; r++) pat[r*COLS +: COLS] = $urandom;
    pat[N-1:NW] = '0;
    load_grid(1, pat, 0, 0, 16'd0);
    nx = life_next(pat, ROWS_W, 1'b1);
    push("t3_rand", 1, nx, 16'd1, nx == pat, 1'b0); step_pulse();

    // reset during the row-7 beat discards the partial load
    for (int r = 0; r < 7; r++) begin
      load_row = $urandom | 32'h1; lv_d = 1'b1;
      @(negedge clk);
    end
    load_row = $urandom; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; lv_d = 1'b0;
    push("t5_rst", 0, '0, 16'd0, 1'b0, 1'b0); pop_check();
    check("t5_ready", N'(lr_d), N'(1'b1));
    for (int r = 0; r < ROWS_D; r++) pat[r*COLS +: COLS] = $urandom;
    load_grid(0, pat, 0, 0, 16'd0);
    push("t5_reload", 0, pat, 16'd0, 1'b0, 1'b0); pop_check();

    // random dead-border step, then a gapped load with step/run held high
    nx = life_next(pat, ROWS_D, 1'b0);
    push("t6_pre", 0, nx, 16'd1, nx == pat, 1'b0); step_pulse();
    for (int r = 0; r < ROWS_D; r++) pat[r*COLS +: COLS] = $urandom;
    load_grid(0, pat, 1, 1, 16'd1);
    push("t6_load", 0, pat, 16'd0, 1'b0, 1'b0); pop_check();
    nx = life_next(pat, ROWS_D, 1'b0);
    push("t6_step", 0, nx, 16'd1, nx == pat, 1'b0); step_pulse();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
